// File: rtl/legv8_ctrl_pkg.sv
// Shared constants for the multicycle LEGv8 control path: state encoding,
// opcode patterns with don't-care masks, ALUOp codes and ALU B-select codes.
// The ALU control decoder imports the ALUOp codes from here as well.
package legv8_ctrl_pkg;

  localparam int unsigned OPC_W  = 11;
  localparam int unsigned ST_W   = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SRCB_W  = 2;

  // Control FSM state encoding (12-15 unused, recover to IDLE)
  typedef enum logic [ST_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_LD    = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_CBZ_EXEC = 4'd9,
    ST_B_EXEC   = 4'd10,
    ST_ILLEGAL  = 4'd11
  } state_e;

  // Opcode patterns; a pattern matches where (op & mask) == (pat & mask)
  localparam logic [OPC_W-1:0] OP_ADD     = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB     = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND     = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR     = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_LDUR    = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR    = 11'b11111000000;
  localparam logic [OPC_W-1:0] OP_CBZ     = 11'b10110100000;
  localparam logic [OPC_W-1:0] OP_B       = 11'b00010100000;
  localparam logic [OPC_W-1:0] MASK_EXACT = 11'b11111111111;
  localparam logic [OPC_W-1:0] MASK_CBZ   = 11'b11111111000;
  localparam logic [OPC_W-1:0] MASK_B     = 11'b11111100000;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select codes
  localparam logic [SRCB_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_DOFF = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_BOFF = 2'b11;

  // One-hot instruction class
  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

  function automatic logic op_match(input logic [OPC_W-1:0] op,
                                    input logic [OPC_W-1:0] pat,
                                    input logic [OPC_W-1:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier.
// Ports:
//   i_opcode   in   IR[31:21]
//   o_class_c  out  one-hot class {rtype, load, store, cbz, b, illegal}
module opcode_class_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output op_class_t        o_class_c
);

  logic w_rtype;
  logic w_load;
  logic w_store;
  logic w_cbz;
  logic w_b;

  always_comb begin
    w_rtype = op_match(i_opcode, OP_ADD, MASK_EXACT) |
              op_match(i_opcode, OP_SUB, MASK_EXACT) |
              op_match(i_opcode, OP_AND, MASK_EXACT) |
              op_match(i_opcode, OP_ORR, MASK_EXACT);
    w_load  = op_match(i_opcode, OP_LDUR, MASK_EXACT);
    w_store = op_match(i_opcode, OP_STUR, MASK_EXACT);
    w_cbz   = op_match(i_opcode, OP_CBZ, MASK_CBZ);
    w_b     = op_match(i_opcode, OP_B, MASK_B);

    o_class_c         = '0;
    o_class_c.rtype   = w_rtype;
    o_class_c.load    = w_load;
    o_class_c.store   = w_store;
    o_class_c.cbz     = w_cbz;
    o_class_c.b       = w_b;
    o_class_c.illegal = ~(w_rtype | w_load | w_store | w_cbz | w_b);
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle LEGv8 datapath: sequences fetch,
// decode, execute, memory and writeback, and drives ALUOp for the ALU
// control decoder. Outputs are decoded from the state register; ir_write
// and pc_write in FETCH are additionally gated by mem_ready.
// Optional build macro MCTRL_RETIRE_CNT_EN adds the 32-bit instr_retired
// counter output.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   opcode            IR[31:21], valid from DECODE on
//   mem_ready         memory completes the current access
//   alu_op            00 add, 01 pass-B, 10 R-type funct
//   alu_src_a/_b      ALU operand selects
//   pc_write(_cond)   PC load (unconditional / on zero), pc_source select
//   ir_write          IR load
//   mem_read/_write   memory requests
//   reg_write, mem_to_reg, reg2loc  register file controls
//   illegal_op        sticky illegal-opcode flag (held in ILLEGAL)
//   state_out         current state, debug
//   instr_retired     retired-instruction count (MCTRL_RETIRE_CNT_EN only)
module multicycle_main_control
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 11,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic [1:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg2loc,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_out
`ifdef MCTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]         instr_retired
`endif
);

  state_e    r_state;
  state_e    w_next;
  op_class_t w_class;
  logic      w_retire;

  opcode_class_decoder u_opcode_class_decoder (
    .i_opcode  (OPC_W'(opcode)),
    .o_class_c (w_class)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    w_next        = ST_IDLE;
    w_retire      = 1'b0;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg2loc       = 1'b0;
    illegal_op    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = ST_DECODE;
        else           w_next = ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = SRCB_BOFF;
        reg2loc   = w_class.store | w_class.cbz;
        if (w_class.illegal)                    w_next = ST_ILLEGAL;
        else if (w_class.rtype)                 w_next = ST_EXEC_R;
        else if (w_class.load | w_class.store)  w_next = ST_MEM_ADDR;
        else if (w_class.cbz)                   w_next = ST_CBZ_EXEC;
        else if (w_class.b)                     w_next = ST_B_EXEC;
        else                                    w_next = ST_ILLEGAL;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_DOFF;
        // Opcode re-sampled here; anything not a load/store is treated as illegal
        if (w_class.load)       w_next = ST_MEM_RD;
        else if (w_class.store) w_next = ST_MEM_WR;
        else                    w_next = ST_ILLEGAL;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) w_next = ST_WB_LD;
        else           w_next = ST_MEM_RD;
      end
      ST_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        reg2loc   = 1'b1;
        w_retire  = mem_ready;
        if (mem_ready) w_next = ST_FETCH;
        else           w_next = ST_MEM_WR;
      end
      ST_CBZ_EXEC: begin
        reg2loc       = 1'b1;
        alu_op        = ALUOP_PASSB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        w_retire      = 1'b1;
        w_next        = ST_FETCH;
      end
      ST_B_EXEC: begin
        pc_write  = 1'b1;
        pc_source = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_ILLEGAL: begin
        illegal_op = 1'b1;
        w_next     = ST_ILLEGAL;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign state_out = STATE_W'(r_state);

`ifdef MCTRL_RETIRE_CNT_EN
  logic [31:0] r_retired;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign instr_retired = r_retired;
`else
  logic w_retire_unused;
  assign w_retire_unused = w_retire;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        mem_ready;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic        pc_write_cond;
  logic        pc_source;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        reg2loc;
  logic        illegal_op;
  logic [3:0]  state_out;
`ifdef MCTRL_RETIRE_CNT_EN
  logic [31:0] instr_retired;
`endif

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110110;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .reg2loc       (reg2loc),
    .illegal_op    (illegal_op),
    .state_out     (state_out)
`ifdef MCTRL_RETIRE_CNT_EN
    ,
    .instr_retired (instr_retired)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction class: 0 R, 1 load, 2 store, 3 cbz, 4 b, 5 illegal
  function automatic int op_class(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
    if (op == OP_LDUR) return 1;
    if (op == 11'b11111000000) return 2;
    if (op[10:3] == 8'b10110100) return 3;
    if (op[10:5] == 6'b000101) return 4;
    return 5;
  endfunction

  function automatic int model_next(input int s, input logic rst, input logic mr,
                                    input logic [10:0] op);
    int c;
    c = op_class(op);
    if (rst) return 0;
    case (s)
      0:  return 1;
      1:  return mr ? 2 : 1;
      2:  return (c == 0) ? 3 : (c == 1 || c == 2) ? 5 : (c == 3) ? 9 : (c == 4) ? 10 : 11;
      3:  return 4;
      5:  return (c == 1) ? 6 : (c == 2) ? 8 : 11;
      6:  return mr ? 7 : 6;
      8:  return mr ? 1 : 8;
      4, 7, 9, 10: return 1;
      11: return 11;
      default: return 0;
    endcase
  endfunction

  // {alu_op, src_a, src_b, pcw, pwc, pcs, irw, mrd, mwr, rw, m2r, r2l, ill}
  function automatic logic [14:0] model_outs(input int s, input logic mr, input logic [10:0] op);
    logic [1:0] aop, sb;
    logic sa, pcw, pwc, pcs, irw, mrd, mwr, rw, m2r, r2l, ill;
    int c;
    c = op_class(op);
    aop = 2'b00; sb = 2'b00;
    {sa, pcw, pwc, pcs, irw, mrd, mwr, rw, m2r, r2l, ill} = '0;
    case (s)
      1:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      2:  begin sb = 2'b11; r2l = (c == 2 || c == 3); end
      3:  begin sa = 1; aop = 2'b10; end
      4:  rw = 1;
      5:  begin sa = 1; sb = 2'b10; end
      6:  mrd = 1;
      7:  begin rw = 1; m2r = 1; end
      8:  begin mwr = 1; r2l = 1; end
      9:  begin r2l = 1; aop = 2'b01; pwc = 1; pcs = 1; end
      10: begin pcw = 1; pcs = 1; end
      11: ill = 1;
      default: ;
    endcase
    return {aop, sa, sb, pcw, pwc, pcs, irw, mrd, mwr, rw, m2r, r2l, ill};
  endfunction

  int          m_state = 0;
  int          m_nx;
  int unsigned m_ret = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    m_nx = model_next(m_state, reset, mem_ready, opcode);
    if (reset) m_ret <= 0;
    else if (m_nx == 1 && (m_state == 4 || m_state == 7 || m_state == 8 ||
                           m_state == 9 || m_state == 10))
      m_ret <= m_ret + 1;
    m_state <= m_nx;
  end

  logic [14:0] dut_vec;
  assign dut_vec = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                    ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg2loc, illegal_op};

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state_out", 32'(state_out), 32'(m_state));
      chk("ctrl_outputs", 32'(dut_vec), 32'(model_outs(m_state, mem_ready, opcode)));
`ifdef MCTRL_RETIRE_CNT_EN
      chk("instr_retired", instr_retired, m_ret);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction from FETCH back to FETCH, inserting wait states
  task automatic run_instr(input logic [10:0] op, input int fetch_stall,
                           input int mem_stall, output int cyc);
    int lf, lm;
    bit left_fetch;
    lf = fetch_stall; lm = mem_stall; left_fetch = 0; cyc = 0;
    opcode = op;
    for (int k = 0; k < 40; k++) begin
      if (state_out == 4'd1 && lf > 0) begin
        mem_ready = 1'b0; lf--;
      end else if ((state_out == 4'd6 || state_out == 4'd8) && lm > 0) begin
        mem_ready = 1'b0; lm--;
      end else begin
        mem_ready = 1'b1;
      end
      tick();
      cyc++;
      if (state_out != 4'd1) left_fetch = 1;
      else if (left_fetch) break;
    end
    mem_ready = 1'b1;
  endtask

  int cyc;

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 11'd0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("idle_state", 32'(state_out), 32'd0);
    chk("idle_outputs", 32'(dut_vec), 32'd0);
    tick(); #1;
    chk("fetch_state", 32'(state_out), 32'd1);
    chk("fetch_mem_read", 32'(mem_read), 32'd1);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_pc_write", 32'(pc_write), 32'd1);
    chk("fetch_alu_src_b", 32'(alu_src_b), 32'd1);

    // ADD: 1 -> 2 -> 3 -> 4 -> 1
    opcode = OP_ADD;
    tick(); #1; chk("add_decode", 32'(state_out), 32'd2);
    tick(); #1; chk("add_exec", 32'(state_out), 32'd3);
    chk("add_exec_alu_op", 32'(alu_op), 32'd2);
    chk("add_exec_no_rw", 32'(reg_write), 32'd0);
    tick(); #1; chk("add_wb", 32'(state_out), 32'd4);
    chk("add_wb_rw", 32'(reg_write), 32'd1);
    tick(); #1; chk("add_back_fetch", 32'(state_out), 32'd1);

    // CBZ
    opcode = OP_CBZ;
    tick(); #1; chk("cbz_decode_reg2loc", 32'(reg2loc), 32'd1);
    tick(); #1; chk("cbz_exec_state", 32'(state_out), 32'd9);
    chk("cbz_alu_op", 32'(alu_op), 32'd1);
    chk("cbz_pc_write_cond", 32'(pc_write_cond), 32'd1);
    chk("cbz_pc_source", 32'(pc_source), 32'd1);
    tick(); #1; chk("cbz_back_fetch", 32'(state_out), 32'd1);

    // Latencies
    run_instr(OP_SUB, 0, 0, cyc);  chk("lat_sub", 32'(cyc), 32'd4);
    run_instr(OP_AND, 0, 0, cyc);  chk("lat_and", 32'(cyc), 32'd4);
    run_instr(OP_ORR, 0, 0, cyc);  chk("lat_orr", 32'(cyc), 32'd4);
    run_instr(OP_LDUR, 0, 0, cyc); chk("lat_ldur", 32'(cyc), 32'd5);
    run_instr(OP_STUR, 0, 0, cyc); chk("lat_stur", 32'(cyc), 32'd4);
    run_instr(OP_CBZ, 0, 0, cyc);  chk("lat_cbz", 32'(cyc), 32'd3);
    run_instr(OP_B, 0, 0, cyc);    chk("lat_b", 32'(cyc), 32'd3);
    run_instr(OP_LDUR, 0, 2, cyc); chk("lat_ldur_stall2", 32'(cyc), 32'd7);
    run_instr(OP_STUR, 0, 3, cyc); chk("lat_stur_stall3", 32'(cyc), 32'd7);
    run_instr(OP_ADD, 2, 0, cyc);  chk("lat_add_fetch_stall2", 32'(cyc), 32'd6);

    // Illegal opcode is sticky until reset
    opcode = OP_BAD;
    tick(); tick(); #1;
    chk("illegal_state", 32'(state_out), 32'd11);
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 11'($urandom);
      tick(); #1;
      chk("illegal_held", 32'(illegal_op), 32'd1);
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("illegal_cleared", 32'(illegal_op), 32'd0);
    chk("illegal_reset_state", 32'(state_out), 32'd0);
    tick();

    // STUR stalled in MEM_WR, then reset
    opcode = OP_STUR;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("stur_mem_wr_state", 32'(state_out), 32'd8);
    chk("stur_mem_write", 32'(mem_write), 32'd1);
    tick(); #1;
    chk("stur_mem_write_held", 32'(mem_write), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("stur_reset_mem_write", 32'(mem_write), 32'd0);
    chk("stur_reset_state", 32'(state_out), 32'd0);
`ifdef MCTRL_RETIRE_CNT_EN
    chk("retired_after_reset", instr_retired, 32'd0);
`endif
    tick();
    run_instr(OP_ADD, 0, 0, cyc);  chk("lat_add_after_reset", 32'(cyc), 32'd4);
    run_instr(OP_B, 0, 0, cyc);    chk("lat_b_after_reset", 32'(cyc), 32'd3);
    run_instr(OP_STUR, 1, 1, cyc); chk("lat_stur_stalls", 32'(cyc), 32'd6);
    #1;
`ifdef MCTRL_RETIRE_CNT_EN
    chk("retired_count_3", instr_retired, 32'd3);
`endif
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
